// File: rtl/dist_avg_filter_if.sv
// Sample/flush inputs and filtered-distance outputs of the distance averaging filter.
interface dist_avg_filter_if #(
  parameter int unsigned W = 14
);
  logic [W-1:0] dist_in;
  logic         dist_valid;
  logic         flush;
  logic [W-1:0] dist_out;
  logic         dist_out_valid;
  logic         no_target;
  logic         primed;

  modport master (
    output dist_in, dist_valid, flush,
    input  dist_out, dist_out_valid, no_target, primed
  );

  modport slave (
    input  dist_in, dist_valid, flush,
    output dist_out, dist_out_valid, no_target, primed
  );
endinterface

// File: rtl/dist_avg_filter.sv
// Power-of-two moving average over accepted distance samples with out-of-range
// rejection and a "no target" flag after a run of consecutive rejects.
module dist_avg_filter #(
  parameter int unsigned W          = 14,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned MAX_DIST   = 4000,
  parameter int unsigned REJ_LIMIT  = 4
) (
  input logic              clk,
  input logic              rst_n,
  dist_avg_filter_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned SW    = W + DEPTH_LOG2;
  localparam int unsigned HALF  = 1 << (DEPTH_LOG2 - 1);
  localparam logic [3:0]  REJ_MAX = 4'(REJ_LIMIT);

  typedef enum logic {EMPTY, RUN} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]            rej_cnt_q, rej_cnt_d;
  logic                  no_target_q, no_target_d;
  logic                  upd_q, upd_d;
  logic                  zero_q, zero_d;
  logic [W-1:0]          dist_out_q, dist_out_d;
  logic                  out_vld_q, out_vld_d;
  logic [W-1:0]          buf_q [DEPTH];
  logic                  prefill, buf_we;
  logic                  accept, reject;
  logic [W-1:0]          avg;

  assign accept = bus.dist_valid && (bus.dist_in != '0) && (bus.dist_in <= W'(MAX_DIST));
  assign reject = bus.dist_valid && !accept;
  assign avg    = W'((sum_q + SW'(HALF)) >> DEPTH_LOG2);

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rej_cnt_d   = rej_cnt_q;
    no_target_d = no_target_q;
    upd_d       = 1'b0;
    zero_d      = 1'b0;
    prefill     = 1'b0;
    buf_we      = 1'b0;
    if (bus.flush) begin
      state_d     = EMPTY;
      sum_d       = '0;
      wr_ptr_d    = '0;
      rej_cnt_d   = '0;
      no_target_d = 1'b0;
    end else if (accept) begin
      rej_cnt_d   = '0;
      no_target_d = 1'b0;
      upd_d       = 1'b1;
      if (state_q == EMPTY) begin
        // Prefill the whole window so the average is exact from the first sample.
        prefill  = 1'b1;
        sum_d    = SW'(bus.dist_in) << DEPTH_LOG2;
        wr_ptr_d = DEPTH_LOG2'(1);
        state_d  = RUN;
      end else begin
        buf_we   = 1'b1;
        sum_d    = sum_q - SW'(buf_q[wr_ptr_q]) + SW'(bus.dist_in);
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
    end else if (reject && (rej_cnt_q < REJ_MAX)) begin
      rej_cnt_d = rej_cnt_q + 4'd1;
      if (rej_cnt_q == REJ_MAX - 4'd1) begin
        no_target_d = 1'b1;
        state_d     = EMPTY;
        zero_d      = 1'b1;
      end
    end
  end

  always_comb begin
    dist_out_d = dist_out_q;
    out_vld_d  = 1'b0;
    if (upd_q) begin
      dist_out_d = avg;
      out_vld_d  = 1'b1;
    end else if (zero_q) begin
      dist_out_d = '0;
      out_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rej_cnt_q   <= '0;
      no_target_q <= 1'b0;
      upd_q       <= 1'b0;
      zero_q      <= 1'b0;
      dist_out_q  <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rej_cnt_q   <= rej_cnt_d;
      no_target_q <= no_target_d;
      upd_q       <= upd_d;
      zero_q      <= zero_d;
      dist_out_q  <= dist_out_d;
      out_vld_q   <= out_vld_d;
    end
  end

  // History storage needs no reset: it is always prefilled before being read.
  always_ff @(posedge clk) begin
    if (prefill) begin
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= bus.dist_in;
    end else if (buf_we) begin
      buf_q[wr_ptr_q] <= bus.dist_in;
    end
  end

  assign bus.dist_out       = dist_out_q;
  assign bus.dist_out_valid = out_vld_q;
  assign bus.no_target      = no_target_q;
  assign bus.primed         = (state_q == RUN);
endmodule
